// File: rtl/ritc_align_sequencer_if.sv
// Control/status and datapath register bus of the RITC alignment sequencer.
interface ritc_align_sequencer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [2:0]  fail_ch;
    logic [3:0]  fail_bit;
    logic        train_on;
    logic        dp_sel;
    logic [3:0]  dp_addr;
    logic        dp_wr;
    logic [31:0] dp_dat;
    logic [2:0]  ch_sel;
    logic [3:0]  bit_sel;
    logic [3:0]  bit_data;

    modport master (
        input  start, bit_data,
        output busy, done, fail, fail_ch, fail_bit, train_on,
               dp_sel, dp_addr, dp_wr, dp_dat, ch_sel, bit_sel
    );

    modport slave (
        output start, bit_data,
        input  busy, done, fail, fail_ch, fail_bit, train_on,
               dp_sel, dp_addr, dp_wr, dp_dat, ch_sel, bit_sel
    );
endinterface

// File: rtl/ritc_align_sequencer.sv
// Training/alignment controller: IDELAY eye scan, centring and bitslip per data bit.
// Optional RITC_ALIGN_DEBUG_EN adds a debug_o status port.
module ritc_align_sequencer #(
    parameter int          NUM_CH        = 6,
    parameter int          NUM_BIT       = 12,
    parameter int          NUM_TAPS      = 32,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          SAMPLES       = 8,
    parameter logic [3:0]  TRAIN_PATTERN = 4'b1010,
    parameter int          MIN_EYE       = 4,
    parameter int          MAX_SLIPS     = 4
) (
    input  logic                   user_clk_i,
    input  logic                   rst_i,
    ritc_align_sequencer_if.master bus
`ifdef RITC_ALIGN_DEBUG_EN
    ,
    output logic [11:0]            debug_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_DP_RESET, S_TRAIN, S_SET_TAP, S_WAIT, S_SAMPLE,
        S_EVAL, S_CENTER, S_SLIP_CHECK, S_SLIP, S_NEXT_BIT, S_DONE
    } state_t;

    state_t      state, state_n, ret;
    logic [1:0]  step;
    logic [15:0] cnt;
    logic [2:0]  ch;
    logic [3:0]  bitn;
    logic [4:0]  tap;
    logic [3:0]  slips;
    logic        fail, fail_now;
    logic [2:0]  fail_ch;
    logic [3:0]  fail_bit;

    logic [3:0]  first_word;
    logic        same;
    logic        good_last;
    logic [5:0]  run_len, best_len, run_len_n;
    logic [4:0]  run_start, best_start, run_start_n, centre;

    logic        dp_sel, dp_wr;
    logic [3:0]  dp_addr;
    logic [31:0] dp_dat;

    logic tap_good, eye_bad, settle_done, sample_done, last_tap, last_bit, pattern_hit, slips_out;

    function automatic logic [31:0] enc(input logic [2:0] c, input logic [3:0] b, input logic [4:0] t);
        return {13'd0, c, 4'd0, b, 3'd0, t};
    endfunction

    assign tap_good    = same && (first_word == 4'b1010 || first_word == 4'b0101);
    assign run_len_n   = tap_good ? run_len + 6'd1 : 6'd0;
    assign run_start_n = (tap_good && run_len == 6'd0) ? tap : run_start;
    assign eye_bad     = best_len < 6'(MIN_EYE);
    assign centre      = eye_bad ? 5'd0 : best_start + best_len[5:1];
    assign settle_done = cnt == 16'(SETTLE_CYCLES - 1);
    assign sample_done = cnt == 16'(SAMPLES - 1);
    assign last_tap    = tap == 5'(NUM_TAPS - 1);
    assign last_bit    = (ch == 3'(NUM_CH - 1)) && (bitn == 4'(NUM_BIT - 1));
    assign pattern_hit = bus.bit_data == TRAIN_PATTERN;
    assign slips_out   = slips == 4'(MAX_SLIPS);
    assign fail_now    = (state == S_CENTER && step == 2'd3 && eye_bad) ||
                         (state == S_SLIP_CHECK && !pattern_hit && slips_out);

    // Bus writes occupy even steps; odd steps are the mandatory idle gap.
    always_comb begin
        state_n = state;
        dp_sel  = 1'b0;
        dp_wr   = 1'b0;
        dp_addr = 4'h0;
        dp_dat  = 32'h0;
        case (state)
            S_IDLE: if (bus.start) state_n = S_DP_RESET;
            S_DONE: state_n = bus.start ? S_DP_RESET : S_IDLE;
            S_DP_RESET: begin
                if (!step[0]) begin
                    dp_sel = 1'b1;
                    dp_wr  = 1'b1;
                    dp_dat = step[1] ? 32'h0 : 32'h2;
                end
                if (step == 2'd3) state_n = S_TRAIN;
            end
            S_TRAIN: if (settle_done) state_n = S_SET_TAP;
            S_SET_TAP, S_CENTER: begin
                if (!step[0]) begin
                    dp_sel  = 1'b1;
                    dp_wr   = 1'b1;
                    dp_addr = step[1] ? 4'h3 : 4'h2;
                    dp_dat  = step[1] ? 32'h1 : enc(ch, bitn, (state == S_CENTER) ? centre : tap);
                end
                if (step == 2'd3) state_n = S_WAIT;
            end
            S_WAIT:   if (settle_done) state_n = ret;
            S_SAMPLE: if (sample_done) state_n = S_EVAL;
            S_EVAL:   state_n = last_tap ? S_CENTER : S_SET_TAP;
            S_SLIP_CHECK: begin
                if (!pattern_hit)     state_n = slips_out ? S_NEXT_BIT : S_SLIP;
                else if (sample_done) state_n = S_NEXT_BIT;
            end
            S_SLIP: begin
                if (step == 2'd0) begin
                    dp_sel  = 1'b1;
                    dp_wr   = 1'b1;
                    dp_addr = 4'h1;
                    dp_dat  = enc(ch, bitn, 5'd0);
                end
                if (step == 2'd1) state_n = S_WAIT;
            end
            S_NEXT_BIT: state_n = last_bit ? S_DONE : S_SET_TAP;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            ret      <= S_IDLE;
            step     <= 2'd0;
            cnt      <= 16'd0;
            ch       <= 3'd0;
            bitn     <= 4'd0;
            tap      <= 5'd0;
            slips    <= 4'd0;
            fail     <= 1'b0;
            fail_ch  <= 3'd0;
            fail_bit <= 4'd0;
        end else begin
            state <= state_n;
            step  <= (state_n != state) ? 2'd0 : step + 2'd1;
            cnt   <= (state_n != state) ? 16'd0 : cnt + 16'd1;
            // Only the first failing bit is recorded; later ones just keep fail set.
            if (fail_now) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_ch  <= ch;
                    fail_bit <= bitn;
                end
            end
            case (state)
                S_IDLE, S_DONE: if (bus.start) begin
                    fail     <= 1'b0;
                    fail_ch  <= 3'd0;
                    fail_bit <= 4'd0;
                    ch       <= 3'd0;
                    bitn     <= 4'd0;
                    tap      <= 5'd0;
                    slips    <= 4'd0;
                end
                S_SET_TAP: ret <= S_SAMPLE;
                S_CENTER:  ret <= eye_bad ? S_NEXT_BIT : S_SLIP_CHECK;
                S_SLIP: begin
                    ret <= S_SLIP_CHECK;
                    if (step == 2'd0) slips <= slips + 4'd1;
                end
                S_EVAL: if (!last_tap) tap <= tap + 5'd1;
                S_NEXT_BIT: begin
                    tap   <= 5'd0;
                    slips <= 4'd0;
                    if (!last_bit) begin
                        if (bitn == 4'(NUM_BIT - 1)) begin
                            bitn <= 4'd0;
                            ch   <= ch + 3'd1;
                        end else begin
                            bitn <= bitn + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Best run only moves on strictly longer runs, so ties keep the earliest eye.
    always_ff @(posedge user_clk_i) begin
        if (state == S_SAMPLE) begin
            if (cnt == 16'd0) begin
                first_word <= bus.bit_data;
                same       <= 1'b1;
            end else if (bus.bit_data != first_word) begin
                same <= 1'b0;
            end
        end
        if (state == S_EVAL) begin
            good_last <= tap_good;
            run_len   <= run_len_n;
            run_start <= run_start_n;
            if (run_len_n > best_len) begin
                best_len   <= run_len_n;
                best_start <= run_start_n;
            end
        end
        if (state == S_TRAIN || state == S_NEXT_BIT) begin
            run_len    <= 6'd0;
            run_start  <= 5'd0;
            best_len   <= 6'd0;
            best_start <= 5'd0;
        end
    end

`ifdef RITC_ALIGN_DEBUG_EN
    logic [11:0] slip_total;

    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            slip_total <= 12'd0;
        end else if ((state == S_IDLE || state == S_DONE) && bus.start) begin
            slip_total <= 12'd0;
        end else if (state == S_SLIP && step == 2'd0) begin
            slip_total <= slip_total + 12'd1;
        end
    end

    assign debug_o = (state == S_DONE) ? slip_total :
                     (state == S_IDLE) ? 12'h0 :
                     {state, best_len, good_last, pattern_hit};
`endif

    assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
    assign bus.done     = state == S_DONE;
    assign bus.train_on = (state != S_IDLE) && (state != S_DP_RESET) && (state != S_DONE);
    assign bus.fail     = fail;
    assign bus.fail_ch  = fail_ch;
    assign bus.fail_bit = fail_bit;
    assign bus.dp_sel   = dp_sel;
    assign bus.dp_wr    = dp_wr;
    assign bus.dp_addr  = dp_addr;
    assign bus.dp_dat   = dp_dat;
    assign bus.ch_sel   = ch;
    assign bus.bit_sel  = bitn;

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Bench: per-bit eye/slip scenario table drives a datapath model; expected bus writes are queued and checked.
module tb_ritc_align_sequencer;
    localparam int NBIT   = 12;
    localparam int NIDX   = 72;
    localparam int SETTLE = 3;
    localparam int NSAMP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ritc_align_sequencer_if bus();
`ifdef RITC_ALIGN_DEBUG_EN
    logic [11:0] debug;
`endif

    ritc_align_sequencer #(.SETTLE_CYCLES(SETTLE), .SAMPLES(NSAMP)) dut (
        .user_clk_i(clk),
        .rst_i(rst),
        .bus(bus)
`ifdef RITC_ALIGN_DEBUG_EN
        ,
        .debug_o(debug)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int lo1; int hi1; int lo2; int hi2; int req; int centre; int nslip; } vec_t;
    typedef struct { logic [3:0] addr; logic [31:0] dat; } wr_t;

    vec_t tbl [NIDX];
    wr_t  exp_q [$];
    int   delay [NIDX];
    int   slipcnt [NIDX];
    int   pend_idx, pend_tap, cyc, errors, checks;
    logic prev_wr;

    function automatic logic [31:0] enc(input int c, input int b, input int t);
        logic [31:0] v;
        v = 32'h0;
        v[18:16] = c[2:0];
        v[11:8]  = b[3:0];
        v[4:0]   = t[4:0];
        return v;
    endfunction

    function automatic logic [3:0] word_of(input int i);
        int d;
        d = delay[i];
        if (!((d >= tbl[i].lo1 && d <= tbl[i].hi1) || (d >= tbl[i].lo2 && d <= tbl[i].hi2)))
            return cyc[0] ? 4'b0011 : 4'b1100;
        return (slipcnt[i] >= tbl[i].req) ? 4'b1010 : 4'b0101;
    endfunction

    function automatic logic [63:0] outs();
        return {8'h0, bus.busy, bus.done, bus.fail, bus.fail_ch, bus.fail_bit, bus.train_on,
                bus.dp_sel, bus.dp_addr, bus.dp_wr, bus.dp_dat, bus.ch_sel, bus.bit_sel};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.dat  = d;
        exp_q.push_back(w);
    endtask

    task automatic build_queue();
        exp_q.delete();
        push(4'h0, 32'h2);
        push(4'h0, 32'h0);
        for (int i = 0; i < NIDX; i++) begin
            for (int t = 0; t < 32; t++) begin
                push(4'h2, enc(i / NBIT, i % NBIT, t));
                push(4'h3, 32'h1);
            end
            push(4'h2, enc(i / NBIT, i % NBIT, tbl[i].centre));
            push(4'h3, 32'h1);
            for (int k = 0; k < tbl[i].nslip; k++) push(4'h1, enc(i / NBIT, i % NBIT, 0));
        end
    endtask

    // One clock: compare any bus write against the scoreboard, update the datapath model, drive samples.
    task automatic tick();
        wr_t e;
        int  idx;
        @(negedge clk);
        cyc++;
        if (bus.dp_wr) begin
            check("wr_gap", {63'h0, prev_wr}, 64'h0);
            check("wr_sel", {63'h0, bus.dp_sel}, 64'h1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, required no write", bus.dp_addr, bus.dp_dat);
            end else begin
                e = exp_q.pop_front();
                check("wr", {28'h0, bus.dp_addr, bus.dp_dat}, {28'h0, e.addr, e.dat});
            end
            case (bus.dp_addr)
                4'h0: if (bus.dp_dat[1]) for (int i = 0; i < NIDX; i++) slipcnt[i] = 0;
                4'h1: begin
                    idx = int'(bus.dp_dat[18:16]) * NBIT + int'(bus.dp_dat[11:8]);
                    if (idx < NIDX) slipcnt[idx]++;
                end
                4'h2: begin
                    pend_idx = int'(bus.dp_dat[18:16]) * NBIT + int'(bus.dp_dat[11:8]);
                    pend_tap = int'(bus.dp_dat[4:0]);
                end
                4'h3: if (bus.dp_dat[0] && pend_idx < NIDX) delay[pend_idx] = pend_tap;
                default: ;
            endcase
        end
        prev_wr = bus.dp_wr;
        idx = int'(bus.ch_sel) * NBIT + int'(bus.bit_sel);
        bus.bit_data = (idx < NIDX) ? word_of(idx) : 4'h0;
    endtask

    initial begin
        int n;
        int qn;
        errors = 0; checks = 0; cyc = 0; prev_wr = 1'b0;
        pend_idx = 0; pend_tap = 0;
        bus.start = 1'b0;
        bus.bit_data = 4'h0;
        // {lo1, hi1, lo2, hi2, slips needed, expected centre, expected slip writes}
        for (int i = 0; i < NIDX; i++) begin
            tbl[i] = '{10, 21, -1, -2, 0, 16, 0};
            delay[i] = 0;
            slipcnt[i] = 0;
        end
        tbl[1]  = '{0, 3, 26, 31, 0, 29, 0};
        tbl[2]  = '{10, 21, -1, -2, 2, 16, 2};
        tbl[18] = '{8, 11, -1, -2, 0, 10, 0};
        tbl[19] = '{2, 7, 20, 25, 0, 5, 0};
        tbl[20] = '{10, 21, -1, -2, 4, 16, 4};
        tbl[29] = '{5, 7, -1, -2, 0, 0, 0};
        tbl[37] = '{10, 21, -1, -2, 5, 16, 4};
        tbl[55] = '{12, 13, -1, -2, 0, 0, 0};
        tbl[60] = '{-1, -2, -1, -2, 0, 0, 0};
        tbl[71] = '{20, 31, -1, -2, 0, 26, 0};

        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", outs(), 64'h0);
        rst = 1'b0;
        tick();
        check("idle_busy", {63'h0, bus.busy}, 64'h0);

        build_queue();
        qn = exp_q.size();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", {63'h0, bus.busy}, 64'h1);
        check("train_off_in_dp_reset", {63'h0, bus.train_on}, 64'h0);
        n = 0;
        while (!bus.train_on && n < 50) begin tick(); n++; end
        check("train_on_after_dp_reset", {63'h0, bus.train_on}, 64'h1);
        check("dp_reset_writes", 64'(exp_q.size()), 64'(qn - 2));

        n = 0;
        while (bus.ch_sel != 3'd1 && n < 20000) begin tick(); n++; end
        check("reach_ch1", {61'h0, bus.ch_sel}, 64'h1);
        check("no_fail_in_ch0", {63'h0, bus.fail}, 64'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_ignored_busy", {63'h0, bus.busy}, 64'h1);

        n = 0;
        while (!bus.done && n < 40000) begin tick(); n++; end
        check("done_pulse", {63'h0, bus.done}, 64'h1);
        check("done_busy_low", {63'h0, bus.busy}, 64'h0);
        check("done_train_off", {63'h0, bus.train_on}, 64'h0);
        check("fail_set", {63'h0, bus.fail}, 64'h1);
        check("fail_ch", {61'h0, bus.fail_ch}, 64'h2);
        check("fail_bit", {60'h0, bus.fail_bit}, 64'h5);
        check("all_writes_seen", 64'(exp_q.size()), 64'h0);
        tick();
        check("done_one_cycle", {63'h0, bus.done}, 64'h0);
        check("fail_sticky", {63'h0, bus.fail}, 64'h1);

        build_queue();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_clears_fail", {56'h0, bus.fail, bus.fail_ch, bus.fail_bit}, 64'h0);
        n = 0;
        while (!(bus.ch_sel == 3'd1 && bus.bit_sel == 4'd3) && n < 20000) begin tick(); n++; end
        check("reach_ch1_bit3", {57'h0, bus.ch_sel, bus.bit_sel}, {57'h0, 3'd1, 4'd3});
        repeat (8) tick();
        check("next_write_pending", {28'h0, exp_q[0].addr, exp_q[0].dat}, {28'h0, 4'h2, enc(1, 3, 1)});
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 64'h0);
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("idle_after_reset", {62'h0, bus.busy, bus.train_on}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ritc_align_sequencer.md
Name: ritc_align_sequencer

Overview:
- Autonomous training/alignment controller for the dual-RITC deserializing datapath.
- Masters the datapath register interface: enables/resets the datapath, asserts training, scans IDELAY per data bit, centres each bit in its eye, then bitslips until the training pattern is word-aligned.
- Sits beside the datapath on the user-clock register bus; software issues start and reads status.

Parameters:
NUM_CH, 6, channels scanned (0..NUM_CH-1)
NUM_BIT, 12, data bits per channel
NUM_TAPS, 32, IDELAY taps (5-bit value)
SETTLE_CYCLES, 16, wait cycles after any datapath write before sampling
SAMPLES, 8, samples taken per tap
TRAIN_PATTERN, 4'b1010, expected 4-sample word when aligned
MIN_EYE, 4, minimum good-tap run for a bit to pass
MAX_SLIPS, 4, bitslips attempted before declaring misalignment

Ports:
user_clk_i  in  1  sole clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  one-cycle start pulse; ignored while busy_o=1
busy_o  out  1  high from accepted start through done
done_o  out  1  one-cycle pulse at completion
fail_o  out  1  sticky until next start; any bit failed eye or slip
fail_ch_o  out  3  channel of first failure
fail_bit_o  out  4  bit of first failure
train_on_o  out  1  training request to RITCs
dp_sel_o  out  1  datapath bus select
dp_addr_o  out  4  datapath register address
dp_wr_o  out  1  single-cycle write strobe
dp_dat_o  out  32  write data
ch_sel_o  out  3  channel steering external sample mux
bit_sel_o  out  4  bit steering external sample mux
bit_data_i  in  4  4 deserialized samples of selected bit, already in user_clk_i domain

Behaviour:
- Interface: clock user_clk_i; reset rst_i is asynchronous and active-high. All outputs 0 in reset; fail_ch_o/fail_bit_o 0.
- Bus: writes are dp_sel_o=dp_wr_o=1 for exactly one cycle, no acknowledgement; at least one idle cycle between writes. Register map: 0x0 {bit1 reset, bit0 disable}; 0x1 bitslip (any write slips the bit named in data); 0x2 IDELAY value; 0x3 IDELAY load (data bit0=1). Data encoding for 0x1/0x2: [18:16] channel, [11:8] bit, [4:0] delay.
- States: IDLE -> DP_RESET (write 0x0 = 0x2, then 0x0 = 0x0) -> TRAIN (train_on_o=1, wait SETTLE_CYCLES) -> SET_TAP (write 0x2, then 0x3=1) -> WAIT (SETTLE_CYCLES) -> SAMPLE (SAMPLES consecutive cycles) -> EVAL -> SET_TAP with next tap, or CENTER after tap NUM_TAPS-1 -> CENTER (write/load chosen tap, WAIT) -> SLIP_CHECK -> SLIP (write 0x1, WAIT) -> SLIP_CHECK ... -> NEXT_BIT -> SET_TAP tap 0 of next bit, or DONE after ch NUM_CH-1 bit NUM_BIT-1 -> IDLE.
- Tap good iff all SAMPLES words equal the first sampled word AND that word is 4'b1010 or 4'b0101 (any rotation of alternating pattern).
- Eye: track longest run of consecutive good taps; run ending at tap NUM_TAPS-1 is closed at scan end; ties keep earliest run. Centre = start + floor(len/2).
- len < MIN_EYE: bit fails, centre loaded as tap 0, slip phase skipped.
- SLIP_CHECK: pass if bit_data_i == TRAIN_PATTERN for SAMPLES consecutive cycles; else slip. After MAX_SLIPS slips still not matching: bit fails.
- On first failure latch fail_ch_o/fail_bit_o; later failures only keep fail_o set. Sequencer always continues to remaining bits.
- DONE: train_on_o=0, busy_o=0, done_o pulse same cycle as return to IDLE.
- start_i while busy: ignored. start_i in IDLE: clears fail_o/fail_ch_o/fail_bit_o, busy_o=1 next cycle.
- rst_i mid-operation: immediate return to IDLE, write strobe dropped, no partial write; datapath registers left as last written.
- ch_sel_o/bit_sel_o valid from first SET_TAP of a bit until NEXT_BIT.

Optional Feature:
- RITC_ALIGN_DEBUG_EN defined: adds output debug_o[11:0] = {state[3:0], eye length[5:0] clipped, last eval good, sample match}; and a per-run counter total slips issued on debug via state==DONE.
- Undefined: no debug_o port; behaviour otherwise identical.

Test Plan:
- Reset then start: first bus writes 0x0=0x00000002 then 0x0=0x00000000; train_on_o=1 after; busy_o=1.
- Model eye good at taps 10..21, pattern aligned: ch0 bit0 centre write 0x2 = 0x00000010 (tap 16); no 0x1 writes.
- Eye good taps 0..3 and 26..31: second run (6) wins, centre tap 29; eye touching last tap handled.
- Model requiring 2 slips: exactly two 0x1 writes for that bit, then next bit begins; fail_o=0.
- Ch2 bit5 eye width 3: fail_o=1, fail_ch_o=2, fail_bit_o=5, tap 0 loaded; later failing bit does not overwrite; done_o pulses after 72 bits.
- Assert rst_i during SAMPLE of ch1 bit3: all outputs 0 asynchronously; start_i during busy ignored (no restart of DP_RESET).
